// File: rtl/mux16_rr_scheduler_if.sv
// mux16_rr_scheduler_if: lane requests, mux select/feedback and downstream valid/ready bundle
interface mux16_rr_scheduler_if #(parameter int LANES = 16, parameter int WIDTH = 16, parameter int SEL_W = 4);
    logic [LANES-1:0] req;
    logic [SEL_W-1:0] sel;
    logic [WIDTH-1:0] mux_out;
    logic [LANES-1:0] grant;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    modport master(output req, mux_out, out_ready, input sel, grant, out_data, out_valid, busy);
    modport slave(input req, mux_out, out_ready, output sel, grant, out_data, out_valid, busy);
endinterface

// File: rtl/mux16_rr_scheduler.sv
// mux16_rr_scheduler: round-robin sharing of one external mux_16 among 16 lanes,
// capturing the selected word and presenting it on a valid/ready handshake.
module mux16_rr_scheduler #(parameter int LANES = 16, parameter int WIDTH = 16, parameter int SEL_W = 4) (
    input logic                  clk,
    input logic                  rst_n,
    mux16_rr_scheduler_if.slave  bus
);
    localparam logic [1:0] IDLE = 2'd0, SELECT = 2'd1, HOLD = 2'd2;
    logic [1:0]       state;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] idx;
    // scan from the farthest offset back to ptr so the nearest requester wins
    always_comb begin
        idx = ptr;
        for (int i = LANES - 1; i >= 0; i--)
            if (bus.req[ptr + SEL_W'(i)]) idx = ptr + SEL_W'(i);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            ptr           <= '0;
            bus.sel       <= '0;
            bus.grant     <= '0;
            bus.out_data  <= WIDTH'(0);
            bus.out_valid <= 1'b0;
        end else begin
            bus.grant <= '0;
            case (state)
                IDLE: if (|bus.req) begin
                    bus.sel <= idx;
                    state   <= SELECT;
                end
                SELECT: begin
                    bus.out_data  <= bus.mux_out;
                    bus.out_valid <= 1'b1;
                    bus.grant     <= LANES'(1) << bus.sel;
                    state         <= HOLD;
                end
                HOLD: if (bus.out_valid && bus.out_ready) begin
                    bus.out_valid <= 1'b0;
                    ptr           <= bus.sel + SEL_W'(1);
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign bus.busy = state != IDLE;
endmodule

// File: doc/mux16_rr_scheduler.md
Name: mux16_rr_scheduler

Overview:
- Round-robin scheduler that shares one mux_16 (256-bit input, 16 lanes of 16 bits, 4-bit select) among 16 requesters.
- Picks a requesting lane, drives the mux select, captures the selected 16-bit word and presents it downstream on a valid/ready handshake.
- Sits between the 16 producer lanes and the single 16-bit consumer path; mux_16 stays combinational and external.

Parameters:
- LANES, 16, number of requesters; fixed at 16 to match mux_16.
- WIDTH, 16, lane word width in bits.
- SEL_W, 4, select width, log2(LANES).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  16  per-lane request; bit k set means lane k holds valid data on the mux input.
- sel  output  4  select to mux_16 S; registered.
- mux_out  input  16  mux_16 out, fed back; combinational function of sel and the lane data.
- grant  output  16  one-hot acknowledge, one-cycle pulse when lane's word is captured.
- out_data  output  16  captured word.
- out_valid  output  1  out_data valid.
- out_ready  input  1  consumer accepts out_data.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (rst_n=0, takes effect immediately without a clock edge):
  - state=IDLE; sel=0; grant=0; out_data=0; out_valid=0; busy=0.
  - rotating pointer ptr=0.
- States: IDLE, SELECT, HOLD.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise, at the edge: search lanes ptr, ptr+1, … ptr+15 (mod 16) and take the first set bit as idx.
  - Register sel<=idx and go to SELECT.
- SELECT (exactly one cycle; gives the mux a full cycle to settle):
  - At the edge: out_data<=mux_out; out_valid<=1; grant<=onehot(sel); go to HOLD.
  - Capture completes even if req[sel] dropped during SELECT.
- HOLD:
  - grant is high only in the first HOLD cycle; cleared on the following edge.
  - out_valid and out_data are held stable until out_ready=1.
  - On the edge with out_valid&&out_ready: out_valid<=0; ptr<=sel+1 (15 wraps to 0); go to IDLE.
  - sel is held through HOLD.
- Latency: req seen in IDLE → sel updated 1 edge later → out_valid/grant 2 edges later.
  - Minimum 3 cycles per transfer with out_ready held at 1.
- Fairness: a lane granted last has the lowest priority next time. Any continuously requesting lane is served within 16 transfers.
- Requesters must keep lane data stable from req assertion until they see grant.
  - A requester that keeps req high after grant is treated as a new request.
- Changes to req during SELECT or HOLD are ignored until the next IDLE evaluation.
- out_ready is ignored while out_valid=0.
- Arithmetic: ptr and search indices are 4-bit and wrap modulo 16. No other arithmetic.
- Reset asserted in any state: all outputs drop to reset values asynchronously. Any in-flight word is discarded with no grant issued.

Test Plan:
- Lane data: lane k = 16'h0100+k.
- Reset: hold rst_n=0 for 3 cycles, then release with req=0 → sel=0, grant=0, out_valid=0, busy=0; remains IDLE.
- Single request: req=16'h0020, out_ready=1 → edge1 sel=5; edge2 out_data=16'h0105, out_valid=1, grant=16'h0020 for one cycle; edge3 out_valid=0, state IDLE.
- All request: req=16'hFFFF held, out_ready=1 → grants appear in lane order 0,1,…,15,0. One word every 3 cycles; out_data tracks 16'h0100…16'h010F.
- Backpressure: req=16'h0008, out_ready=0 for 5 cycles after out_valid rises → out_data stays 16'h0103, out_valid stays 1, grant pulses only once. Raising out_ready completes the transfer on the next edge.
- Wrap-around: after a grant to lane 14, apply req=16'h8001 → next grant lane 15 (16'h8000), then lane 0 (16'h0001).
- Reset mid-transfer: assert rst_n=0 in HOLD with out_valid=1 → out_valid=0 before the next edge. After release with req=16'h0003, lane 0 is granted first (ptr=0).
